// File: rtl/day_month_if.sv
// Bus bundle for the day/month calendar counter: control inputs, year
// for the leap decision, and the registered date plus year carry.
interface day_month_if;
    logic        en_1;
    logic        up;
    logic        down;
    logic [2:0]  select_item;
    logic        carry_in;
    logic [11:0] year_bin;
    logic [4:0]  day_bin;
    logic [3:0]  month_bin;
    logic        carry_out;

    // Driver side: supplies controls and year, observes the date
    modport master (
        output en_1, up, down, select_item, carry_in, year_bin,
        input  day_bin, month_bin, carry_out
    );

    // Counter side: consumes controls and year, produces the date
    modport slave (
        input  en_1, up, down, select_item, carry_in, year_bin,
        output day_bin, month_bin, carry_out
    );
endinterface

// File: rtl/day_month.sv
// Day-of-month / month counter with manual adjust, leap-year aware
// month lengths, clamping of dates made invalid by a year change, and
// a combinational year carry on the Dec 31 -> Jan 1 wrap.
module day_month #(
    parameter logic [2:0] SELECT_DAY   = 3'b011,
    parameter logic [2:0] SELECT_MONTH = 3'b100
) (
    input  logic        clk_1Hz,
    input  logic        rst_n,
    day_month_if.slave  bus
);

    logic [4:0] day_q, day_d;
    logic [3:0] month_q, month_d;
    logic       leap_year;
    logic [4:0] cur_dim;
    logic       sel_day;
    logic       sel_month;
    logic       count_en;

    // Month length for a given month and leap flag
    function automatic logic [4:0] month_days(input logic [3:0] m, input logic leap);
        case (m)
            4'd2:                      return leap ? 5'd29 : 5'd28;
            4'd4, 4'd6, 4'd9, 4'd11:   return 5'd30;
            default:                   return 5'd31;
        endcase
    endfunction

    // Gregorian leap rule: /4, except centuries unless /400
    assign leap_year = (bus.year_bin[1:0] == 2'b00) &&
                       (((bus.year_bin % 12'd100) != 12'd0) ||
                        ((bus.year_bin % 12'd400) == 12'd0));

    assign cur_dim   = month_days(month_q, leap_year);
    assign sel_day   = (bus.select_item == SELECT_DAY);
    assign sel_month = (bus.select_item == SELECT_MONTH);
    assign count_en  = bus.en_1 && bus.carry_in;

    // Next-date selection: day adjust, then month adjust, then clamp/count/hold
    always_comb begin
        logic [3:0] month_adj;
        logic [4:0] new_dim;
        day_d     = day_q;
        month_d   = month_q;
        month_adj = month_q;
        new_dim   = cur_dim;
        if (sel_day) begin
            if (bus.up) begin
                day_d = (day_q >= cur_dim) ? 5'd1 : day_q + 5'd1;
            end else if (bus.down) begin
                // An out-of-range day steps down to the month end as well
                day_d = (day_q == 5'd1 || day_q > cur_dim) ? cur_dim : day_q - 5'd1;
            end else if (day_q > cur_dim) begin
                day_d = cur_dim;
            end
        end else if (sel_month) begin
            if (bus.up) begin
                month_adj = (month_q >= 4'd12) ? 4'd1 : month_q + 4'd1;
            end else if (bus.down) begin
                month_adj = (month_q <= 4'd1) ? 4'd12 : month_q - 4'd1;
            end
            new_dim = month_days(month_adj, leap_year);
            month_d = month_adj;
            day_d   = (day_q > new_dim) ? new_dim : day_q;
        end else if (day_q > cur_dim) begin
            // Year change left an impossible date: pull back to month end, no count
            day_d = cur_dim;
        end else if (count_en) begin
            if (day_q < cur_dim) begin
                day_d = day_q + 5'd1;
            end else begin
                day_d   = 5'd1;
                month_d = (month_q >= 4'd12) ? 4'd1 : month_q + 4'd1;
            end
        end
    end

    // Date registers, forced to 01/01 while reset is low
    always_ff @(posedge clk_1Hz or negedge rst_n) begin
        if (!rst_n) begin
            day_q   <= 5'd1;
            month_q <= 4'd1;
        end else begin
            day_q   <= day_d;
            month_q <= month_d;
        end
    end

    assign bus.day_bin   = day_q;
    assign bus.month_bin = month_q;
    // Year advances on the same edge as the Dec 31 wrap; adjust modes never carry
    assign bus.carry_out = count_en && (month_q == 4'd12) && (day_q == 5'd31) &&
                           !sel_day && !sel_month;

endmodule

// File: tb/tb_day_month.sv
// Self-checking bench for day_month: scoreboard of expected dates pushed
// as stimulus is driven and popped after each rising edge.
module tb_day_month;

    localparam logic [2:0] SEL_NONE  = 3'b000;
    localparam logic [2:0] SEL_DAY   = 3'b011;
    localparam logic [2:0] SEL_MONTH = 3'b100;

    typedef struct {
        string tag;
        int    d;
        int    m;
    } exp_t;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;
    int   md;
    int   mm;
    exp_t sb[$];

    day_month_if bus_if();

    day_month #(
        .SELECT_DAY   (SEL_DAY),
        .SELECT_MONTH (SEL_MONTH)
    ) dut (
        .clk_1Hz (clk),
        .rst_n   (rst_n),
        .bus     (bus_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int tb_dim(input int m, input int yr);
        bit leap;
        leap = (yr % 4 == 0) && ((yr % 100 != 0) || (yr % 400 == 0));
        case (m)
            2:             return leap ? 29 : 28;
            4, 6, 9, 11:   return 30;
            default:       return 31;
        endcase
    endfunction

    // One edge: drive, check carry before the edge, push expectation, pop after
    task automatic step(input string tag, input logic en, input logic ci,
                        input logic u, input logic dn, input logic [2:0] sel,
                        input int yr, input int ed, input int em, input logic eco);
        exp_t e;
        bus_if.en_1        = en;
        bus_if.carry_in    = ci;
        bus_if.up          = u;
        bus_if.down        = dn;
        bus_if.select_item = sel;
        bus_if.year_bin    = yr[11:0];
        #1;
        chk({tag, "_carry"}, int'(bus_if.carry_out), int'(eco));
        sb.push_back('{tag, ed, em});
        @(posedge clk);
        #1;
        e = sb.pop_front();
        chk({e.tag, "_day"}, int'(bus_if.day_bin), e.d);
        chk({e.tag, "_month"}, int'(bus_if.month_bin), e.m);
        md = ed;
        mm = em;
        $display("%-12s y=%0d -> %0d/%0d (exp %0d/%0d) carry_before=%0b",
                 tag, yr, bus_if.month_bin, bus_if.day_bin, em, ed, eco);
    endtask

    // Counting edge whose expectation comes from the calendar model
    task automatic count_step(input string tag, input int yr);
        int ed, em;
        logic eco;
        eco = (md == 31) && (mm == 12);
        if (md > tb_dim(mm, yr)) begin
            ed = tb_dim(mm, yr); em = mm; eco = 1'b0;
        end else if (md < tb_dim(mm, yr)) begin
            ed = md + 1; em = mm;
        end else begin
            ed = 1; em = (mm == 12) ? 1 : mm + 1;
        end
        step(tag, 1'b1, 1'b1, 1'b0, 1'b0, SEL_NONE, yr, ed, em, eco);
    endtask

    task automatic do_reset();
        bus_if.en_1 = 1'b0; bus_if.carry_in = 1'b0;
        bus_if.up = 1'b0; bus_if.down = 1'b0;
        bus_if.select_item = SEL_NONE;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        md = 1; mm = 1;
    endtask

    // Reach a date from 01/01 by month-up then day-up adjusts
    task automatic set_date(input int m, input int d, input int yr);
        do_reset();
        for (int i = 1; i < m; i++)
            step("set_mon", 1'b0, 1'b0, 1'b1, 1'b0, SEL_MONTH, yr, 1, i + 1, 1'b0);
        for (int i = 1; i < d; i++)
            step("set_day", 1'b0, 1'b0, 1'b1, 1'b0, SEL_DAY, yr, i + 1, m, 1'b0);
    endtask

    initial begin
        checks = 0; errors = 0;
        rst_n = 1'b1;
        bus_if.en_1 = 1'b0; bus_if.carry_in = 1'b0;
        bus_if.up = 1'b0; bus_if.down = 1'b0;
        bus_if.select_item = SEL_NONE;
        bus_if.year_bin = 12'd2001;
        #1 rst_n = 1'b0;
        #1;
        chk("rst_day", int'(bus_if.day_bin), 1);
        chk("rst_month", int'(bus_if.month_bin), 1);
        chk("rst_carry", int'(bus_if.carry_out), 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        md = 1; mm = 1;

        // 31 count edges in 2001 land on Feb 1 without carry
        for (int i = 0; i < 31; i++) count_step("cnt2001", 2001);
        chk("feb1_day", md, 1);
        chk("feb1_month", mm, 2);

        // Year wrap: carry before the edge, 01/01 and no carry after
        set_date(12, 31, 2099);
        count_step("wrap", 2099);
        step("post_wrap", 1'b1, 1'b1, 1'b0, 1'b0, SEL_NONE, 2100, 2, 1, 1'b0);

        // Leap-year handling at Feb 28
        set_date(2, 28, 2024);
        count_step("leap2024a", 2024);
        count_step("leap2024b", 2024);
        set_date(2, 28, 2100);
        count_step("nleap2100", 2100);
        set_date(2, 28, 2400);
        count_step("leap2400", 2400);

        // Month adjust clamps day; up wins over down
        set_date(1, 31, 2001);
        step("m_up", 1'b0, 1'b0, 1'b1, 1'b0, SEL_MONTH, 2001, 28, 2, 1'b0);
        step("m_down", 1'b0, 1'b0, 1'b0, 1'b1, SEL_MONTH, 2001, 28, 1, 1'b0);
        step("m_both", 1'b0, 1'b0, 1'b1, 1'b1, SEL_MONTH, 2001, 28, 2, 1'b0);
        step("m_hold", 1'b1, 1'b1, 1'b0, 1'b0, SEL_MONTH, 2001, 28, 2, 1'b0);

        // Year change off Feb 29 clamps; counting is suppressed that edge
        set_date(2, 29, 2024);
        step("clamp", 1'b1, 1'b1, 1'b0, 1'b0, SEL_NONE, 2025, 28, 2, 1'b0);
        do_reset();
        step("d_down", 1'b1, 1'b1, 1'b0, 1'b1, SEL_DAY, 2001, 31, 1, 1'b0);

        // Adjust wraps at Dec 31 never carry even with count enabled
        set_date(12, 31, 2001);
        step("dec_dup", 1'b1, 1'b1, 1'b1, 1'b0, SEL_DAY, 2001, 1, 12, 1'b0);
        set_date(12, 31, 2001);
        step("dec_mup", 1'b1, 1'b1, 1'b1, 1'b0, SEL_MONTH, 2001, 31, 1, 1'b0);

        // Count across Feb 29 in 2024 against the model
        do_reset();
        for (int i = 0; i < 62; i++) count_step("cnt2024", 2024);

        // Asynchronous reset mid-count at 07/15
        set_date(7, 15, 2001);
        bus_if.en_1 = 1'b1; bus_if.carry_in = 1'b1;
        #3 rst_n = 1'b0;
        #1;
        chk("arst_day", int'(bus_if.day_bin), 1);
        chk("arst_month", int'(bus_if.month_bin), 1);
        chk("arst_carry", int'(bus_if.carry_out), 0);
        @(posedge clk);
        #1;
        chk("arst_hold_day", int'(bus_if.day_bin), 1);
        chk("arst_hold_month", int'(bus_if.month_bin), 1);
        rst_n = 1'b1;
        md = 1; mm = 1;
        step("post_rst", 1'b0, 1'b1, 1'b0, 1'b0, SEL_NONE, 2001, 1, 1, 1'b0);
        count_step("post_cnt", 2001);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/day_month.md
DAY_MONTH -- requirements
Module: day_month

Interface
REQ-001: Parameter SELECT_DAY, default 3'b011, select_item code that places the day field in adjust mode.
REQ-002: Parameter SELECT_MONTH, default 3'b100, select_item code that places the month field in adjust mode.
REQ-003: clk_1Hz  input  1  sole clock; all state changes on its rising edge.
REQ-004: rst_n  input  1  asynchronous, active-low reset.
REQ-005: en_1  input  1  counting enable; qualifies carry_in.
REQ-006: up  input  1  adjust increment request for the selected field.
REQ-007: down  input  1  adjust decrement request for the selected field.
REQ-008: select_item  input  3  adjust-field selector, shared with the other time/date counters.
REQ-009: carry_in  input  1  day-advance request from the hour counter's midnight rollover.
REQ-010: year_bin  input  12  current year, binary, 2001..3000; used only for the leap-year decision.
REQ-011: day_bin  output  5  day of month, binary, 1..31, registered.
REQ-012: month_bin  output  4  month, binary, 1..12, registered.
REQ-013: carry_out  output  1  year-advance request, combinational, drives the year counter's carry_in.

Function
REQ-014: Leap year SHALL be computed from year_bin: divisible by 4 and (not divisible by 100 or divisible by 400); 2100, 2200, 2300, 2500, 2600, 2700, 2900, 3000 are non-leap; 2400 is leap.
REQ-015: days_in_month SHALL be 31 for months 1,3,5,7,8,10,12; 30 for 4,6,9,11; 29 for month 2 in a leap year, otherwise 28.
REQ-016: Mode priority per edge SHALL be: select_item==SELECT_DAY adjust, then select_item==SELECT_MONTH adjust, then count (en_1 && carry_in), then hold.
REQ-017: Within any adjust mode, up SHALL take priority over down; neither asserted -> hold.
REQ-018: Day adjust up: day_bin==days_in_month -> 1, else +1; month unchanged.
REQ-019: Day adjust down: day_bin==1 -> days_in_month, else -1; month unchanged.
REQ-020: Month adjust up: 12 -> 1, else +1; down: 1 -> 12, else -1.
REQ-021: On a month adjust, if day_bin exceeds days_in_month of the new month (same year), day_bin SHALL load that maximum on the same edge; otherwise day_bin is unchanged.
REQ-022: Count: day_bin < days_in_month -> day +1; day_bin==days_in_month and month<12 -> day 1, month +1; day_bin==days_in_month and month==12 -> day 1, month 1.
REQ-023: Clamp: in any hold or count cycle where day_bin > days_in_month (e.g. year adjusted from a leap year while on Feb 29), the edge SHALL load day_bin = days_in_month; this takes precedence over count, and no carry is produced.
REQ-024: carry_out SHALL be 1 exactly when en_1 && carry_in && month_bin==12 && day_bin==31 && select_item is neither SELECT_DAY nor SELECT_MONTH; otherwise 0.
REQ-025: The year counter advances on the same edge as the Dec 31 -> Jan 1 wrap, so the date-to-year latency is 0 cycles.
REQ-026: Adjust operations SHALL never assert carry_out, including Dec 31 day-up or month-up wraps.
REQ-027: Outputs SHALL never leave the ranges 1..31 and 1..12 and SHALL never hold a date invalid for year_bin for more than one edge.

Reset
REQ-028: While rst_n==0, day_bin SHALL be 1 and month_bin SHALL be 1, independent of the clock; carry_out is therefore 0.
REQ-029: Reset asserted mid-adjust or mid-count SHALL abort the operation; the first edge after release applies normal rules from 01/01.

Verification
REQ-030: Reset, then en_1=1, carry_in=1, select_item=000 for 31 edges, year_bin=2001 -> day 1 month 2 (Feb 1); no carry_out seen.
REQ-031: Set 12/31, year_bin=2099, en_1=carry_in=1 -> carry_out=1 before the edge; after the edge, 01/01 with carry_out=0.
REQ-032: Set 02/28 with count pulses: year_bin=2024 -> 02/29 then 03/01; year_bin=2100 -> 03/01 directly; year_bin=2400 -> 02/29.
REQ-033: Set 01/31, select_item=SELECT_MONTH, up=1, year_bin=2001 -> 02/28; then down=1 -> 01/28; up and down both 1 -> month increments.
REQ-034: Set 02/29 with year_bin=2024, change year_bin to 2025, hold -> next edge gives 02/28; select_item=SELECT_DAY with down from 01/01 -> 01/31, with carry_out=0 throughout.
REQ-035: Assert rst_n=0 asynchronously mid-count at 07/15 between edges -> outputs read 01/01 immediately; hold 01/01 until the first enabled edge after release.
